// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// operation encodings, FSM state encodings and the default datapath width.
package mdu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] CALC   = 2'b01;
    localparam logic [1:0] FINISH = 2'b10;

endpackage

// File: rtl/mult_div_unit_twos_negate.sv
// Conditional two's-complement negation, used for operand magnitudes
// and for sign correction of product, quotient and remainder.
module twos_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         en,
    output logic [W-1:0] y
);

    assign y = en ? (~a + W'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers,
// one iteration per cycle over WIDTH cycles, plus direct MTHI/MTLO writes.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;

    logic               op_div;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   new_rem;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign busy      = (state != IDLE);

    twos_negate #(.W(WIDTH)) u_neg_a (
        .a(a), .en(op_signed & a[WIDTH-1]), .y(a_mag)
    );
    twos_negate #(.W(WIDTH)) u_neg_b (
        .a(b), .en(op_signed & b[WIDTH-1]), .y(b_mag)
    );

    // Multiply: multiplier sits in the low half and shifts out as the
    // partial product grows into the high half.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (acc[0] ? mcand : '0)};
    assign mul_next = {add_sum, acc[WIDTH-1:1]};

    // Divide: remainder in the high half, dividend bits shift in from the
    // low half while quotient bits fill it from the bottom.
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand};
    assign q_bit    = ~trial[WIDTH];
    assign new_rem  = q_bit ? trial[WIDTH-1:0]
                            : {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
    assign div_next = {new_rem, acc[WIDTH-2:0], q_bit};

    twos_negate #(.W(2*WIDTH)) u_neg_prod (
        .a(acc), .en(neg_res), .y(prod_fix)
    );
    twos_negate #(.W(WIDTH)) u_neg_quot (
        .a(acc[WIDTH-1:0]), .en(neg_res), .y(quot_fix)
    );
    twos_negate #(.W(WIDTH)) u_neg_rem (
        .a(acc[2*WIDTH-1:WIDTH]), .en(neg_rem), .y(rem_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            mcand    <= '0;
            acc      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        state    <= CALC;
                        count    <= '0;
                        is_div   <= op_div;
                        neg_res  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= op_signed & a[WIDTH-1];
                        b_zero   <= (b == '0);
                        a_orig   <= a;
                        mcand    <= op_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        div_zero <= 1'b0;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    if (is_div) begin
                        if (b_zero) begin
                            hi <= a_orig;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    div_zero <= is_div & b_zero;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected
// HI/LO/div_zero; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            done_cnt++;
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                e = sbq.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
                check({e.name, "_dz"}, {31'b0, div_zero}, {31'b0, e.dz});
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input int inj,
                          output int lat, output int bcnt);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        e.hi = eh;
        e.lo = el;
        e.dz = ez;
        e.name = name;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op = ~o;
        a = $urandom;
        b = $urandom;
        lat = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (inj != 0 && lat == inj) begin
                start = 1'b1;
                op = DIVU;
                a = 32'd1;
                b = 32'd1;
                mthi = 1'b1;
                wdata = 32'h0000DEAD;
            end else if (inj != 0 && lat == inj + 1) begin
                start = 1'b0;
                mthi = 1'b0;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done", name);
            sbq.delete();
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dc;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dz", {31'b0, div_zero}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, 0, lat, bcnt);
        check("latency", lat, 34);
        check("busy_cycles", bcnt, 33);

        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0, lat, bcnt);
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, lat, bcnt);
        run_op("div_negb", DIV, 32'd7, 32'hFFFFFFFE,
               32'h00000001, 32'hFFFFFFFD, 1'b0, 0, lat, bcnt);
        run_op("divu_big", DIVU, 32'hFFFFFFFF, 32'h10,
               32'h0000000F, 32'h0FFFFFFF, 1'b0, 0, lat, bcnt);
        run_op("divu_zero", DIVU, 32'd100, 32'd0,
               32'h00000064, 32'hFFFFFFFF, 1'b1, 0, lat, bcnt);
        run_op("multu_clr", MULTU, 32'd2, 32'd3,
               32'd0, 32'd6, 1'b0, 0, lat, bcnt);
        run_op("div_zero_s", DIV, 32'hFFFFFF00, 32'd0,
               32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 0, lat, bcnt);
        run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
               32'd0, 32'h80000000, 1'b0, 0, lat, bcnt);

        // MTHI/MTLO while idle
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mt_both_hi", hi, 32'h12345678);
        check("mt_both_lo", lo, 32'h12345678);
        mtlo = 1'b1;
        wdata = 32'h000000A5;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_hi", hi, 32'h12345678);
        check("mtlo_lo", lo, 32'h000000A5);

        // start and mthi while busy are both ignored
        dc = done_cnt;
        run_op("multu_busy", MULTU, 32'd7, 32'd9,
               32'd0, 32'd63, 1'b0, 5, lat, bcnt);
        repeat (40) @(negedge clk);
        check("one_done", done_cnt - dc, 1);
        check("busy_after", {31'b0, busy}, 32'd0);

        // reset mid-operation aborts with no result
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        op = DIVU;
        a = 32'd50;
        b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_nodone", done_cnt - dc, 0);

        run_op("divu_fresh", DIVU, 32'd50, 32'd7,
               32'd1, 32'd7, 1'b0, 0, lat, bcnt);
        repeat (3) @(negedge clk);
        check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
